// File: rtl/video_axis_pattern_gen.sv
// Synthetic AXI4-Stream video source: programmable blanking and four test patterns.
// Define VIDEO_GEN_MOVING_EN to scroll the ramp-H/checker patterns one pixel per frame.
module video_axis_pattern_gen #(
  parameter int DATA_WIDTH = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int H_BLANK    = 160,
  parameter int V_BLANK    = 45
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  // state  | meaning
  // S_IDLE | counters parked at 0, waiting for enable at a frame boundary
  // S_RUN  | h/v counters sweeping active + blanking region of a frame

  localparam int H_TOT = IMG_WIDTH + H_BLANK;
  localparam int V_TOT = IMG_HEIGHT + V_BLANK;
  localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
  localparam int XW    = (DATA_WIDTH > 4) ? DATA_WIDTH : 4;

  localparam logic [HW-1:0] H_MAX      = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_LAST_ACT = HW'(IMG_WIDTH - 1);
  localparam logic [VW-1:0] V_MAX      = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_LAST_ACT = VW'(IMG_HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] FLAT_GREY = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_h_cnt;
  logic [HW-1:0]   w_h_nxt;
  logic [VW-1:0]   r_v_cnt;
  logic [VW-1:0]   w_v_nxt;
  logic [1:0]      r_pat_q;
  logic [1:0]      w_pat_nxt;
  logic            w_frame_wrap;
  logic            w_active;
  logic            w_done;
  logic [7:0]      w_offset;
  logic [XW-1:0]   w_x;
  logic [XW-1:0]   w_y;
  logic [DATA_WIDTH-1:0] w_pix;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_pat_q <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_pat_q <= w_pat_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_h_nxt      = r_h_cnt;
    w_v_nxt      = r_v_cnt;
    w_pat_nxt    = r_pat_q;
    w_frame_wrap = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (enable) begin
          w_state_nxt = S_RUN;
          w_pat_nxt   = pattern;
        end
      end
      S_RUN: begin
        if (r_h_cnt == H_MAX) begin
          w_h_nxt = '0;
          if (r_v_cnt == V_MAX) begin
            // enable and pattern only matter here, so frames are never cut short
            w_v_nxt      = '0;
            w_frame_wrap = 1'b1;
            if (enable) w_pat_nxt = pattern;
            else        w_state_nxt = S_IDLE;
          end else begin
            w_v_nxt = r_v_cnt + 1'b1;
          end
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef VIDEO_GEN_MOVING_EN
  logic [7:0] r_offset;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n)            r_offset <= 8'd0;
    else if (w_frame_wrap) r_offset <= r_offset + 1'b1;
  end

  assign w_offset = r_offset;
`else
  assign w_offset = 8'd0;
`endif

  assign w_active = (r_state == S_RUN) && (r_h_cnt <= H_LAST_ACT) && (r_v_cnt <= V_LAST_ACT);
  assign w_done   = w_active && (r_h_cnt == H_LAST_ACT) && (r_v_cnt == V_LAST_ACT);
  assign w_x      = XW'(r_h_cnt) + XW'(w_offset);
  assign w_y      = XW'(r_v_cnt);

  always_comb begin
    w_pix = '0;
    case (r_pat_q)
      2'b00:   w_pix = w_x[DATA_WIDTH-1:0];
      2'b01:   w_pix = w_y[DATA_WIDTH-1:0];
      2'b10:   w_pix = (w_x[3] ^ w_y[3]) ? '1 : '0;
      default: w_pix = FLAT_GREY;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= 16'd0;
    end else begin
      m_axis_tdata  <= w_active ? w_pix : '0;
      m_axis_tuser  <= w_active && (r_h_cnt == '0) && (r_v_cnt == '0);
      m_axis_tlast  <= w_active && (r_h_cnt == H_LAST_ACT);
      m_axis_tvalid <= w_active;
      frame_done    <= w_done;
      if (w_done) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: doc/video_axis_pattern_gen.md
# video_axis_pattern_gen

Synthetic video source that drives an AXI4-Stream video stream (tuser = start of frame, tlast = end of line, tvalid, no tready) into the edge-detection pipeline's slave input. It sits in front of the Sobel/line-buffer chain. It replaces the camera front-end in simulation and in hardware bring-up. It generates frames of a selectable test pattern with programmable horizontal and vertical blanking.

## Interface
- DATA_WIDTH, 10: pixel width in bits.
- IMG_WIDTH, 640: active pixels per line (≥2).
- IMG_HEIGHT, 480: active lines per frame (≥1).
- H_BLANK, 160: idle cycles after each line's active pixels (≥0).
- V_BLANK, 45: idle lines (each IMG_WIDTH+H_BLANK cycles) after the active lines (≥0).

Ports:
- pixel_clk, in, 1: sole clock; all logic on rising edge.
- rst_n, in, 1: synchronous reset, active-low.
- enable, in, 1: run request; sampled only at frame boundaries.
- pattern, in, 2: 00 horizontal ramp, 01 vertical ramp, 10 8×8 checkerboard, 11 flat mid-grey.
- m_axis_tdata, out, DATA_WIDTH: pixel value.
- m_axis_tuser, out, 1: high on first beat of frame only.
- m_axis_tlast, out, 1: high on last beat of each line.
- m_axis_tvalid, out, 1: beat qualifier; no backpressure.
- frame_done, out, 1: one-cycle pulse coincident with last beat of frame.
- frame_cnt, out, 16: completed frames, wraps 0xFFFF→0.

## Operation
- The FSM has two states, IDLE and RUN.
- IDLE: counters held at 0. When enable=1 at an edge, the FSM latches pattern into pat_q and enters RUN.
- RUN: h_cnt counts 0..IMG_WIDTH+H_BLANK-1. At wrap, v_cnt increments over 0..IMG_HEIGHT+V_BLANK-1.
- A cycle is active when h_cnt<IMG_WIDTH and v_cnt<IMG_HEIGHT.
- At frame wrap (h and v both at max):
  - If enable=1: pattern is re-latched, RUN continues, and the next frame starts on the following cycle.
  - If enable=0: the FSM returns to IDLE.
- Deasserting enable mid-frame never truncates a frame.
- Pattern changes mid-frame are ignored until the next frame boundary.
- Pixel value, using x=h_cnt+offset and y=v_cnt, truncated to DATA_WIDTH:
  - Ramp H: x mod 2^DATA_WIDTH.
  - Ramp V: y mod 2^DATA_WIDTH.
  - Checker: all-ones when x[3]^y[3]=1, else 0.
  - Flat: 2^(DATA_WIDTH-1).
- offset = 0 unless the feature in Configuration is compiled in.
- tuser=1 when h=0 and v=0. tlast=1 when h=IMG_WIDTH-1 and v<IMG_HEIGHT.
- frame_done=1 when h=IMG_WIDTH-1 and v=IMG_HEIGHT-1. frame_cnt increments on that same beat.
- When the stream is idle (blanking or IDLE state), tvalid=0, tuser=0, tlast=0 and tdata=0.

## Timing
- Reset: state IDLE, counters 0, all outputs 0 (tdata, tuser, tlast, tvalid, frame_done, frame_cnt) on the cycle after the edge with rst_n=0.
- Reset overrides everything, including mid-frame. The next frame after release starts from h=v=0 with tuser.
- Outputs are registered from counter state, giving 1 cycle of latency.
  - enable=1 sampled at edge k in IDLE → counters valid after edge k.
  - First beat (tuser=1, tdata for x=0) is visible after edge k+1.
- Beats within a line are back-to-back, IMG_WIDTH consecutive cycles.
- Line period is IMG_WIDTH+H_BLANK cycles.
- Frame period is (IMG_WIDTH+H_BLANK)×(IMG_HEIGHT+V_BLANK) cycles.
- With H_BLANK=V_BLANK=0 and enable held high, the stream is continuous: the next tuser follows the frame_done beat on the next cycle.
- The registered outputs drain one cycle after returning to IDLE. The last frame's final beat is always emitted.

## Configuration
- VIDEO_GEN_MOVING_EN defined:
  - An 8-bit offset register, reset to 0, increments by 1 at each frame boundary and wraps 255→0.
  - It is applied to x for the ramp-H and checker patterns, so the pattern scrolls one pixel per frame.
- VIDEO_GEN_MOVING_EN undefined: offset is constant 0, no register is synthesised, and every frame is identical.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with enable=1 → all outputs 0. Release → first tuser beat appears 2 edges after release, with tdata=0.
- Geometry: IMG_WIDTH=8, IMG_HEIGHT=4, H_BLANK=4, V_BLANK=2, pattern=00 → per frame:
  - 32 beats, tdata 0..7 on each line.
  - tlast on every 8th beat, tuser on beat 1 only.
  - frame_done coincident with beat 32.
  - Next tuser 72 cycles after the previous tuser.
- Enable drop: deassert enable during line 1 of frame 0 → all 32 beats are still emitted, then tvalid stays 0. frame_cnt=1.
- Pattern switch: IMG_WIDTH=16, change 00→10 during line 2 → rest of frame 0 stays ramp. Frame 1 line 0 is 0×8 followed by all-ones×8.
- Moving: with VIDEO_GEN_MOVING_EN, pattern=00 → frame 1 line 0 tdata = 1..8. Frame 256 returns to 0..7.
- Mid-frame reset: rst_n=0 for 1 cycle during line 2 → outputs 0 next cycle, frame_cnt=0. The restart yields a full 32-beat frame starting with tuser.
